// File: rtl/alu_issue_ctrl_if.sv
// Bundle of request, ALU-side and result signals for the ALU issue controller.
// The slave modport is the controller's view; master is the surrounding environment.
`timescale 1ns/1ps

interface alu_issue_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_sel;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic             alu_enable;
    logic [WIDTH-1:0] alu_salida;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_error;
    logic [CNT_W-1:0] op_count;
    logic [CNT_W-1:0] err_count;

    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_salida, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, alu_enable,
               out_valid, out_result, out_error, op_count, err_count
    );

    modport master (
        output in_valid, in_a, in_b, in_sel, alu_salida, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, alu_enable,
               out_valid, out_result, out_error, op_count, err_count
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 32-bit ALU: accepts a request, drives the ALU for one
// cycle, captures its result and holds it until the downstream handshake.
`timescale 1ns/1ps

module alu_issue_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             sel_supported;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            result_q  <= '0;
            error_q   <= 1'b0;
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            result_q  <= result_d;
            error_q   <= error_d;
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        result_d      = result_q;
        error_d       = error_q;
        op_cnt_d      = op_cnt_q;
        err_cnt_d     = err_cnt_q;
        sel_supported = (bus.in_sel != 3'b101) && (bus.in_sel != 3'b110);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    alu_a_d   = bus.in_a;
                    alu_b_d   = bus.in_b;
                    alu_sel_d = bus.in_sel;
                    // Unsupported opcodes skip the ALU and complete as an error
                    if (sel_supported) begin
                        state_d = EXEC;
                    end else begin
                        state_d  = DONE;
                        result_d = '0;
                        error_d  = 1'b1;
                    end
                end
            end
            EXEC: begin
                result_d = bus.alu_salida;
                error_d  = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    if (error_q) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else begin
                        op_cnt_d = op_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.alu_enable = (state_q == EXEC);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.out_result = result_q;
    assign bus.out_error  = error_q;
    assign bus.op_count   = op_cnt_q;
    assign bus.err_count  = err_cnt_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed scenarios followed by random
// requests with random backpressure, checked against a cycle-level reference model.
`timescale 1ns/1ps

module tb_alu_issue_ctrl;
    localparam int WIDTH   = 32;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       sel;
        logic [WIDTH-1:0] result;
        logic             err;
    } expect_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in ALU; drives a marker value when disabled so a stray capture is visible
    always_comb begin
        if (!bus.alu_enable) begin
            bus.alu_salida = 32'hDEAD_BEEF;
        end else begin
            case (bus.alu_sel)
                3'b000:  bus.alu_salida = bus.alu_a & bus.alu_b;
                3'b001:  bus.alu_salida = bus.alu_a | bus.alu_b;
                3'b010:  bus.alu_salida = bus.alu_a + bus.alu_b;
                3'b011:  bus.alu_salida = bus.alu_a - bus.alu_b;
                3'b100:  bus.alu_salida = ~(bus.alu_a & bus.alu_b);
                3'b111:  bus.alu_salida = bus.alu_a * bus.alu_b;
                default: bus.alu_salida = 32'hBAD0_0BAD;
            endcase
        end
    end

    int      checks = 0;
    int      fails  = 0;
    expect_t sb[$];
    expect_t cur;
    bit      pend      = 1'b0;
    bit      pendOk    = 1'b0;
    int      age       = 0;
    int      modelOps  = 0;
    int      modelErrs = 0;
    bit      justReset = 1'b0;
    bit      randReady = 1'b0;

    function automatic expect_t refOp(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [2:0] sel);
        expect_t e;
        logic [2*WIDTH-1:0] prod;
        e.a   = a;
        e.b   = b;
        e.sel = sel;
        e.err = 1'b0;
        prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (sel)
            3'd0:    e.result = a & b;
            3'd1:    e.result = a | b;
            3'd2:    e.result = a + b;
            3'd3:    e.result = a - b;
            3'd4:    e.result = ~(a & b);
            3'd7:    e.result = prod[WIDTH-1:0];
            default: begin
                e.result = '0;
                e.err    = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Monitor: model the expected cycle-level view and pop the scoreboard on handshakes
    always @(negedge clk) begin
        expect_t e;
        if (rst) begin
            sb.delete();
            pend      = 1'b0;
            modelOps  = 0;
            modelErrs = 0;
            justReset = 1'b1;
        end else begin
            if (justReset) begin
                checkOutput("reset alu_a", 64'(bus.alu_a), 64'd0);
                checkOutput("reset alu_b", 64'(bus.alu_b), 64'd0);
                checkOutput("reset alu_sel", 64'(bus.alu_sel), 64'd0);
                checkOutput("reset out_result", 64'(bus.out_result), 64'd0);
                checkOutput("reset out_error", 64'(bus.out_error), 64'd0);
                justReset = 1'b0;
            end
            if (pend) age++;
            checkOutput("in_ready", 64'(bus.in_ready), 64'(!pend));
            checkOutput("alu_enable", 64'(bus.alu_enable), 64'(pend && pendOk && age == 1));
            checkOutput("out_valid", 64'(bus.out_valid), 64'(pend && age >= (pendOk ? 2 : 1)));
            checkOutput("op_count", 64'(bus.op_count), 64'(modelOps));
            checkOutput("err_count", 64'(bus.err_count), 64'(modelErrs));
            if (bus.alu_enable && pend) begin
                checkOutput("alu_a", 64'(bus.alu_a), 64'(cur.a));
                checkOutput("alu_b", 64'(bus.alu_b), 64'(cur.b));
                checkOutput("alu_sel", 64'(bus.alu_sel), 64'(cur.sel));
            end
            if (bus.out_valid && sb.size() != 0) begin
                checkOutput("out_result", 64'(bus.out_result), 64'(sb[0].result));
                checkOutput("out_error", 64'(bus.out_error), 64'(sb[0].err));
                if (bus.out_ready) begin
                    e = sb.pop_front();
                    if (e.err) modelErrs = (modelErrs + 1) % (1 << CNT_W);
                    else       modelOps  = (modelOps + 1) % (1 << CNT_W);
                    pend = 1'b0;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e = refOp(bus.in_a, bus.in_b, bus.in_sel);
                sb.push_back(e);
                cur    = e;
                pend   = 1'b1;
                pendOk = !e.err;
                age    = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present one request and return just after the edge that accepted it
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] sel);
        int waited;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        bus.in_valid = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.in_ready && waited < TIMEOUT);
        if (!bus.in_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL accept timeout: in_ready 0 after %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_sel   = 3'($urandom_range(0, 7));
    endtask

    task automatic waitDrain();
        int waited = 0;
        while ((pend || sb.size() != 0) && waited < TIMEOUT) begin
            @(posedge clk);
            waited++;
        end
        #1;
        if (pend || sb.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain timeout: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] AND and back-to-back supported ops");
        applyStimulus(32'd4201, 32'd6669, 3'b000);
        applyStimulus(32'd4201, 32'd6669, 3'b001);
        applyStimulus(32'd8, 32'd16, 3'b010);
        applyStimulus(32'd6, 32'd12, 3'b011);
        applyStimulus(32'd10, 32'd24, 3'b111);
        waitDrain();

        $display("[TB] unsupported opcodes");
        applyStimulus(32'd8, 32'd16, 3'b110);
        applyStimulus(32'd84, 32'd36, 3'b101);
        waitDrain();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(32'd222, 32'd23, 3'b010);
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        waitDrain();

        $display("[TB] reset during EXEC");
        applyStimulus(32'd4, 32'd100, 3'b111);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] counter wrap");
        repeat (5) applyStimulus(32'd220, 32'd220, 3'b011);
        waitDrain();

        $display("[TB] random requests with random backpressure");
        randReady = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus($urandom, $urandom, 3'($urandom_range(0, 7)));
        end
        randReady = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        waitDrain();
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
